tictactoe_turn_ctrl: RTL and testbench

Game sequencer for the tic-tac-toe design. It owns the 3x3 board register, the cursor, whose turn it is, the per-turn timeout and win/draw detection, and turns debounced button levels into placements. It replaces the ad-hoc glue between cursor, occupancy, turn and winner logic with one FSM. Board and status outputs feed the display/LED logic directly.

---
 rtl/tictactoe_turn_ctrl_if.sv | 23 ++
 rtl/tictactoe_turn_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_tictactoe_turn_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tictactoe_turn_ctrl_if.sv
// Button inputs and display/status outputs of the tic-tac-toe turn controller.
// The master side drives the debounced buttons; the slave side is the controller.
interface tictactoe_turn_ctrl_if;
    logic        move_i;
    logic        sel_i;
    logic [3:0]  cursor_o;
    logic [17:0] board_o;
    logic        player_o;
    logic [1:0]  winner_o;
    logic        game_over_o;
    logic        reject_o;
    logic        timeout_o;

    modport master (
        output move_i, sel_i,
        input  cursor_o, board_o, player_o, winner_o, game_over_o, reject_o, timeout_o
    );

    modport slave (
        input  move_i, sel_i,
        output cursor_o, board_o, player_o, winner_o, game_over_o, reject_o, timeout_o
    );
endinterface

// File: rtl/tictactoe_turn_ctrl.sv
// Tic-tac-toe game sequencer: board, cursor, turn, per-turn timeout and win/draw
// detection, driven by rising edges of the debounced move/select buttons.
module tictactoe_turn_ctrl #(
    parameter int TURN_CYCLES = 250_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    tictactoe_turn_ctrl_if.slave bus
);
    localparam int TW = $clog2(TURN_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TURN_CYCLES - 1);

    // Eight winning lines, three 4-bit cell indices each, line 0 in the low bits.
    localparam logic [95:0] LINES = {
        4'd6, 4'd4, 4'd2,   4'd8, 4'd4, 4'd0,
        4'd8, 4'd5, 4'd2,   4'd7, 4'd4, 4'd1,
        4'd6, 4'd3, 4'd0,   4'd8, 4'd7, 4'd6,
        4'd5, 4'd4, 4'd3,   4'd2, 4'd1, 4'd0
    };

    typedef enum logic [1:0] {TURN, CHECK, DONE} state_t;

    state_t          state_reg,   state_next;
    logic [3:0]      cursor_reg,  cursor_next;
    logic [17:0]     board_reg,   board_next;
    logic            player_reg,  player_next;
    logic [1:0]      winner_reg,  winner_next;
    logic [TW-1:0]   timer_reg,   timer_next;
    logic            over_reg,    over_next;
    logic            reject_reg,  reject_next;
    logic            timeout_reg, timeout_next;
    logic            move_q_reg;
    logic            sel_q_reg;

    logic            move_edge;
    logic            sel_edge;
    logic [1:0]      mark;
    logic [8:0]      occ;
    logic [8:0]      mine;
    logic [7:0]      line_hit;
    logic [3:0]      free_idx;
    logic            cur_occ;
    logic            place_en;
    logic [3:0]      place_idx;

    assign move_edge = bus.move_i & ~move_q_reg;
    assign sel_edge  = bus.sel_i  & ~sel_q_reg;
    assign mark      = player_reg ? 2'b10 : 2'b01;
    assign cur_occ   = occ[cursor_reg];

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_cell
            assign occ[gi]  = |board_reg[2*gi +: 2];
            assign mine[gi] = (board_reg[2*gi +: 2] == mark);
        end
        for (gi = 0; gi < 8; gi++) begin : g_line
            localparam int CA = int'(LINES[gi*12 +: 4]);
            localparam int CB = int'(LINES[gi*12 + 4 +: 4]);
            localparam int CC = int'(LINES[gi*12 + 8 +: 4]);
            assign line_hit[gi] = mine[CA] & mine[CB] & mine[CC];
        end
    endgenerate

    // Lowest-index empty cell, target of an automatic placement.
    always_comb begin
        free_idx = 4'd0;
        for (int k = 8; k >= 0; k--) begin
            if (!occ[k]) begin
                free_idx = 4'(k);
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        cursor_next  = cursor_reg;
        board_next   = board_reg;
        player_next  = player_reg;
        winner_next  = winner_reg;
        timer_next   = timer_reg;
        reject_next  = 1'b0;
        timeout_next = 1'b0;
        place_en     = 1'b0;
        place_idx    = cursor_reg;

        case (state_reg)
            TURN: begin
                timer_next = timer_reg + TW'(1);
                if (move_edge) begin
                    cursor_next = (cursor_reg == 4'd8) ? 4'd0 : cursor_reg + 4'd1;
                end
                // A valid select wins over the timeout; an occupied select loses to it.
                if (sel_edge && !cur_occ) begin
                    place_en  = 1'b1;
                    place_idx = cursor_reg;
                end else if (timer_reg == TIMER_LAST) begin
                    place_en     = 1'b1;
                    place_idx    = free_idx;
                    timeout_next = 1'b1;
                end else if (sel_edge) begin
                    reject_next = 1'b1;
                end
                if (place_en) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (|line_hit) begin
                    winner_next = mark;
                    state_next  = DONE;
                end else if (&occ) begin
                    winner_next = 2'b11;
                    state_next  = DONE;
                end else begin
                    player_next = ~player_reg;
                    timer_next  = '0;
                    state_next  = TURN;
                end
            end
            DONE: begin
                if (sel_edge) begin
                    board_next  = '0;
                    winner_next = 2'b00;
                    player_next = 1'b0;
                    cursor_next = 4'd0;
                    timer_next  = '0;
                    state_next  = TURN;
                end
            end
            default: begin
                state_next = TURN;
            end
        endcase

        for (int k = 0; k < 9; k++) begin
            if (place_en && (place_idx == 4'(k))) begin
                board_next[2*k +: 2] = mark;
            end
        end

        over_next = (state_next == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= TURN;
            cursor_reg  <= 4'd0;
            board_reg   <= '0;
            player_reg  <= 1'b0;
            winner_reg  <= 2'b00;
            timer_reg   <= '0;
            over_reg    <= 1'b0;
            reject_reg  <= 1'b0;
            timeout_reg <= 1'b0;
            // Held-high buttons must not look like edges after reset.
            move_q_reg  <= 1'b1;
            sel_q_reg   <= 1'b1;
        end else begin
            state_reg   <= state_next;
            cursor_reg  <= cursor_next;
            board_reg   <= board_next;
            player_reg  <= player_next;
            winner_reg  <= winner_next;
            timer_reg   <= timer_next;
            over_reg    <= over_next;
            reject_reg  <= reject_next;
            timeout_reg <= timeout_next;
            move_q_reg  <= bus.move_i;
            sel_q_reg   <= bus.sel_i;
        end
    end

    assign bus.cursor_o    = cursor_reg;
    assign bus.board_o     = board_reg;
    assign bus.player_o    = player_reg;
    assign bus.winner_o    = winner_reg;
    assign bus.game_over_o = over_reg;
    assign bus.reject_o    = reject_reg;
    assign bus.timeout_o   = timeout_reg;
endmodule

// File: tb/tb_tictactoe_turn_ctrl.sv
// Scoreboard bench for tictactoe_turn_ctrl: a game-level model predicts the outputs
// after every clock edge; a separate monitor compares them against the DUT.
module tb_tictactoe_turn_ctrl;
    localparam int TC = 32;

    typedef struct packed {
        logic [3:0]  cursor;
        logic [17:0] board;
        logic        player;
        logic [1:0]  winner;
        logic        over;
        logic        rej;
        logic        to;
    } snap_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    snap_t exp_q[$];

    tictactoe_turn_ctrl_if tb_if();

    tictactoe_turn_ctrl #(.TURN_CYCLES(TC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (tb_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Game model: cells hold 0 empty, 1 X, 2 O; phase 0 play, 1 judge, 2 over.
    localparam int LN [24] = '{0,1,2, 3,4,5, 6,7,8, 0,3,6, 1,4,7, 2,5,8, 0,4,8, 2,4,6};
    int mb [9];
    int m_cur, m_ply, m_win, m_phase, m_tmr;
    bit m_pm, m_ps, m_rej, m_to;

    function automatic bit has_line(input int who);
        for (int l = 0; l < 8; l++) begin
            if (mb[LN[3*l]] == who && mb[LN[3*l+1]] == who && mb[LN[3*l+2]] == who) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit has_empty();
        for (int k = 0; k < 9; k++) begin
            if (mb[k] == 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_step(input bit mv, input bit sl, input bit r);
        bit me;
        bit se;
        int target;
        if (r) begin
            for (int k = 0; k < 9; k++) mb[k] = 0;
            m_cur = 0; m_ply = 0; m_win = 0; m_phase = 0; m_tmr = 0;
            m_pm = 1'b1; m_ps = 1'b1; m_rej = 1'b0; m_to = 1'b0;
            return;
        end
        me = mv && !m_pm;
        se = sl && !m_ps;
        m_pm = mv;
        m_ps = sl;
        m_rej = 1'b0;
        m_to = 1'b0;
        if (m_phase == 0) begin
            target = -1;
            if (se && mb[m_cur] == 0) begin
                target = m_cur;
            end else if (m_tmr == TC - 1) begin
                m_to = 1'b1;
                for (int k = 8; k >= 0; k--) if (mb[k] == 0) target = k;
            end else if (se) begin
                m_rej = 1'b1;
            end
            if (me) m_cur = (m_cur + 1) % 9;
            if (target >= 0) begin
                mb[target] = m_ply + 1;
                m_phase = 1;
            end else begin
                m_tmr++;
            end
        end else if (m_phase == 1) begin
            if (has_line(m_ply + 1)) begin
                m_win = m_ply + 1;
                m_phase = 2;
            end else if (!has_empty()) begin
                m_win = 3;
                m_phase = 2;
            end else begin
                m_ply = 1 - m_ply;
                m_tmr = 0;
                m_phase = 0;
            end
        end else if (se) begin
            for (int k = 0; k < 9; k++) mb[k] = 0;
            m_cur = 0; m_ply = 0; m_win = 0; m_tmr = 0; m_phase = 0;
        end
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s.cursor = 4'(m_cur);
        s.board  = '0;
        for (int k = 0; k < 9; k++) s.board[2*k +: 2] = 2'(mb[k]);
        s.player = 1'(m_ply);
        s.winner = 2'(m_win);
        s.over   = (m_phase == 2);
        s.rej    = m_rej;
        s.to     = m_to;
        return s;
    endfunction

    task automatic compare(input snap_t e, input string tag);
        snap_t a;
        a.cursor = tb_if.cursor_o;
        a.board  = tb_if.board_o;
        a.player = tb_if.player_o;
        a.winner = tb_if.winner_o;
        a.over   = tb_if.game_over_o;
        a.rej    = tb_if.reject_o;
        a.to     = tb_if.timeout_o;
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s t=%0t actual: cur=%0d board=%05h ply=%0b win=%0d over=%0b rej=%0b to=%0b required: cur=%0d board=%05h ply=%0b win=%0d over=%0b rej=%0b to=%0b",
                     tag, $time, a.cursor, a.board, a.player, a.winner, a.over, a.rej, a.to,
                     e.cursor, e.board, e.player, e.winner, e.over, e.rej, e.to);
        end
    endtask

    // Monitor: one expected snapshot per clock edge.
    initial begin
        snap_t e;
        snap_t prev;
        prev = '0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                compare(e, "edge");
                if (e.board != prev.board && e.board != '0)
                    $display("txn place t=%0t board=%05h to=%0b", $time, e.board, e.to);
                if (e.rej)
                    $display("txn reject t=%0t cursor=%0d", $time, e.cursor);
                if (e.winner != prev.winner && e.winner != 2'b00)
                    $display("txn result t=%0t winner=%0d", $time, e.winner);
                prev = e;
            end
        end
    end

    task automatic cyc(input bit mv, input bit sl, input bit r);
        @(negedge clk);
        tb_if.move_i = mv;
        tb_if.sel_i  = sl;
        rst = r;
        model_step(mv, sl, r);
        exp_q.push_back(model_snap());
        if (r) begin
            #1;
            compare(model_snap(), "async_rst");
        end
    endtask

    task automatic press_move();
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_sel();
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic goto_cell(input int c);
        for (int i = 0; i < 9 && m_cur != c && m_phase == 0; i++) press_move();
    endtask

    task automatic play(input int c);
        goto_cell(c);
        press_sel();
    endtask

    task automatic do_reset(input bit sl);
        cyc(1'b0, sl, 1'b1);
        cyc(1'b0, sl, 1'b1);
        cyc(1'b0, sl, 1'b0);
    endtask

    task automatic wait_timer_last();
        for (int i = 0; i < 4 * TC && m_phase == 0 && m_tmr != TC - 1; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic play_list(input int cells [9], input int n);
        for (int i = 0; i < n; i++) play(cells[i]);
    endtask

    initial begin
        int draw_seq [9];
        int win9_seq [9];
        int win_seq  [9];
        checks = 0;
        failures = 0;
        rst = 1'b1;
        tb_if.move_i = 1'b0;
        tb_if.sel_i  = 1'b0;
        draw_seq = '{0, 1, 2, 3, 5, 4, 6, 8, 7};
        win9_seq = '{0, 1, 2, 3, 4, 5, 7, 6, 8};
        win_seq  = '{0, 3, 1, 4, 2, 0, 0, 0, 0};

        // Reset, two moves and a select: X lands on cell 2.
        do_reset(1'b0);
        press_move();
        press_move();
        press_sel();
        cyc(1'b0, 1'b0, 1'b0);

        // X wins on the top row; move ignored in DONE; select restarts.
        do_reset(1'b0);
        play_list(win_seq, 5);
        press_move();
        press_sel();

        // Occupied select is rejected, then O places elsewhere.
        play(4);
        press_sel();
        play(0);

        // Timeout auto-placement into the lowest free cell.
        do_reset(1'b0);
        play(1);
        play(0);
        for (int i = 0; i < TC + 4; i++) cyc(1'b0, 1'b0, 1'b0);

        // Select on the timeout edge: empty cell, then occupied cell.
        do_reset(1'b0);
        play(0);
        play(1);
        goto_cell(3);
        wait_timer_last();
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        wait_timer_last();
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

        // Move and select on the same edge.
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

        // Full board without a line, then a win on the ninth move.
        do_reset(1'b0);
        play_list(draw_seq, 9);
        do_reset(1'b0);
        play_list(win9_seq, 9);

        // Reset during CHECK with select held through release.
        do_reset(1'b0);
        goto_cell(3);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        press_move();

        // Random play, busy then sparse enough for timeouts, with rare resets.
        for (int i = 0; i < 800; i++)
            cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 299) == 0));
        for (int i = 0; i < 800; i++)
            cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 59) == 0), 1'b0);

        cyc(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
